bp_update_ctrl: RTL and testbench
=================================

# bp_update_ctrl

Write-port controller for the branch predictor tables (BHT tag, BTT target, 2-bit direction counters). It sits between the ALU branch-resolution outputs and the predictor's single table write port. It buffers resolved-branch updates in a small FIFO and walks all table entries to clear them after reset or on a flush request. It also gates `predict_en` so fetch ignores predictions while the tables are stale.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, PC width
- `IDX_W`, 8, table index width (256 entries, index = pc[IDX_W+1:2])
- `FIFO_DEPTH`, 2, update-queue depth (power of two, ≥2)

Ports:
- `cpu_clk` in 1: clock
- `cpu_rstn` in 1: asynchronous active-low reset
- `flush_req` in 1: single-cycle pulse (fence.i / debug); invalidate all entries
- `branch_ex` in 1: resolved branch valid
- `branch_pc_ex` in ADDR_WIDTH: resolved branch PC
- `branch_taken_ex` in 1: resolved direction
- `branch_target_ex` in ADDR_WIDTH: resolved target
- `tbl_wr_stall` in 1: table wrapper cannot accept a write this cycle
- `tbl_wen` out 1: table write strobe
- `tbl_clr` out 1: qualifies `tbl_wen`; write valid=0, counter=2'b01
- `tbl_waddr` out IDX_W: write index
- `tbl_w_pc` out ADDR_WIDTH: tag to write
- `tbl_w_target` out ADDR_WIDTH: target to write
- `tbl_w_taken` out 1: direction for the table's saturating counter step
- `predict_en` out 1: predictions usable by fetch
- `clear_busy` out 1: clear walk in progress

## Operation
- FSM states: CLEAR, RUN.
- Reset enters CLEAR with index 0 and the FIFO empty.
- CLEAR behaviour:
  - Each non-stalled cycle: `tbl_wen`=`tbl_clr`=1, `tbl_waddr`=index, index+1.
  - After index 2^IDX_W−1 is written, go to RUN.
  - `branch_ex` is dropped. No FIFO write.
- RUN behaviour:
  - `branch_ex` pushes {pc, target, taken} into the FIFO.
  - The head entry is popped and written when the FIFO is non-empty and `tbl_wr_stall`=0: `tbl_wen`=1, `tbl_clr`=0, `tbl_waddr`=pc[IDX_W+1:2].
- FIFO full, `branch_ex` arrives, no pop this cycle: the new update is dropped and the FIFO contents are unchanged.
- FIFO full with a pop in the same cycle: push and pop both occur.
- `flush_req` in any state:
  - Next state is CLEAR, index reset to 0, FIFO emptied. Queued updates are stale and discarded.
  - `flush_req` during CLEAR restarts the walk at 0.
- `flush_req` and `branch_ex` in the same cycle: flush wins and the update is dropped.
- `tbl_wr_stall`=1: no write is issued in either state, index and FIFO head hold, outputs other than `tbl_wen` may change.
- `predict_en`=1 only in RUN. `clear_busy`=1 only in CLEAR.

## Timing
- Reset values: `tbl_wen`=0, `tbl_clr`=0, `tbl_waddr`=0, `tbl_w_pc`=0, `tbl_w_target`=0, `tbl_w_taken`=0, `predict_en`=0, `clear_busy`=1.
- All `tbl_*` outputs are registered.
- Update latency: `branch_ex` in cycle N gives `tbl_wen` in cycle N+1 when the FIFO is empty and there is no stall.
- Throughput: one write per cycle.
- Clear walk: exactly 2^IDX_W write cycles plus stalled cycles. `predict_en` rises the cycle after the last clear write.
- `flush_req` in cycle N: `predict_en`=0 and `clear_busy`=1 in N+1. The first clear write (index 0) is in N+1.
- Reset asserted mid-walk or mid-update: immediate return to the reset values, then a full walk from 0.

## Configuration
- `BP_UPDATE_STATS_EN` defined adds the following:
  - Output `stat_upd_cnt` [15:0]: successful update writes.
  - Output `stat_drop_cnt` [15:0]: dropped updates, counting full, CLEAR and flush drops.
  - Both counters saturate at 16'hFFFF, reset to 0, and are not cleared by `flush_req`.
- `BP_UPDATE_STATS_EN` undefined: the ports and counters are absent and behaviour is otherwise identical.

## Structure
- Shared core package/defines: `ADDR_WIDTH`, `BP_IDX_W`, FSM state encoding (CLEAR=1'b0, RUN=1'b1), and the clear counter value 2'b01.
- One sub-module: `bp_upd_fifo`, a synchronous FIFO of {pc, target, taken} with push, pop, full, empty and sync clear.

## Test plan
- Reset release with `tbl_wr_stall`=0: 256 consecutive clear writes at indices 0..255, `predict_en`=1 at cycle 257, no `tbl_wen` afterwards.
- RUN state, `branch_ex` with pc=32'h0000_0104, target=32'h0000_0200, taken=1: next cycle `tbl_wen`=1, `tbl_waddr`=8'h41, `tbl_w_target`=32'h200, `tbl_w_taken`=1.
- `tbl_wr_stall` held 3 cycles while `branch_ex` fires on 3 consecutive cycles (depth 2): first two are written in order after the stall, the third is dropped (`stat_drop_cnt`=1 with `BP_UPDATE_STATS_EN`).
- `flush_req` with 2 queued updates: no update writes, clear walk restarts at 0, `predict_en`=0 the next cycle.
- `flush_req` at walk index 100: the next write is index 0 and the total walk completes 256 writes later.
- `flush_req` coincident with `branch_ex`: the update is never written.

Source files
------------

// File: rtl/bp_update_ctrl_pkg.sv
// Shared definitions for the branch-predictor table write-port controller:
// default widths, FSM state encoding and the counter value written on clear.
package bp_update_ctrl_pkg;

    localparam int BP_ADDR_WIDTH = 32;
    localparam int BP_IDX_W      = 8;

    // Direction-counter value the table wrapper writes when tbl_clr qualifies tbl_wen
    localparam logic [1:0] BP_CLR_CNT = 2'b01;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } bp_state_e;

endpackage

// File: rtl/bp_update_ctrl_fifo.sv
// bp_upd_fifo: small synchronous FIFO holding packed {pc, target, taken}
// updates. Wrap-bit pointers give full/empty; clr_i empties it in one cycle.
module bp_upd_fifo #(
    parameter int W     = 65,
    parameter int DEPTH = 2
) (
    input  logic         cpu_clk,
    input  logic         cpu_rstn,
    input  logic         clr_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] wdata_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wptr_q;
    logic [AW:0]  rptr_q;

    // Status flags and head data from the pointer pair
    always_comb begin
        empty_o = (wptr_q == rptr_q);
        full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        rdata_o = mem_q[rptr_q[AW-1:0]];
    end

    // Pointer advance; clear has priority over push/pop
    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            wptr_q <= {(AW+1){1'b0}};
            rptr_q <= {(AW+1){1'b0}};
        end else if (clr_i) begin
            wptr_q <= {(AW+1){1'b0}};
            rptr_q <= {(AW+1){1'b0}};
        end else begin
            if (push_i) begin
                wptr_q <= wptr_q + {{AW{1'b0}}, 1'b1};
            end
            if (pop_i) begin
                rptr_q <= rptr_q + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Storage write; a push while full is only issued alongside a pop of the same slot
    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {W{1'b0}};
            end
        end else if (push_i && !clr_i) begin
            mem_q[wptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/bp_update_ctrl.sv
// bp_update_ctrl: owns the predictor tables' single write port. Walks every
// index with clear writes after reset or flush_req, then writes resolved
// branch updates queued in bp_upd_fifo. An empty queue with no stall writes
// the incoming update straight through for one-cycle latency.
// Optional statistics counters: define BP_UPDATE_STATS_EN.
module bp_update_ctrl
    import bp_update_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = BP_ADDR_WIDTH,
    parameter int IDX_W      = BP_IDX_W,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  cpu_clk,
    input  logic                  cpu_rstn,
    input  logic                  flush_req,
    input  logic                  branch_ex,
    input  logic [ADDR_WIDTH-1:0] branch_pc_ex,
    input  logic                  branch_taken_ex,
    input  logic [ADDR_WIDTH-1:0] branch_target_ex,
    input  logic                  tbl_wr_stall,
    output logic                  tbl_wen,
    output logic                  tbl_clr,
    output logic [IDX_W-1:0]      tbl_waddr,
    output logic [ADDR_WIDTH-1:0] tbl_w_pc,
    output logic [ADDR_WIDTH-1:0] tbl_w_target,
    output logic                  tbl_w_taken,
    output logic                  predict_en,
    output logic                  clear_busy
`ifdef BP_UPDATE_STATS_EN
    ,
    output logic [15:0]           stat_upd_cnt,
    output logic [15:0]           stat_drop_cnt
`endif
);
    localparam int               UW       = 2 * ADDR_WIDTH + 1;
    localparam logic [IDX_W-1:0] IDX_LAST = {IDX_W{1'b1}};

    bp_state_e             state_q;
    logic [IDX_W-1:0]      idx_q;
    logic                  tbl_wen_q;
    logic                  tbl_clr_q;
    logic [IDX_W-1:0]      tbl_waddr_q;
    logic [ADDR_WIDTH-1:0] tbl_w_pc_q;
    logic [ADDR_WIDTH-1:0] tbl_w_target_q;
    logic                  tbl_w_taken_q;
    logic                  predict_en_q;
    logic                  clear_busy_q;

    logic [UW-1:0]         in_upd_s;
    logic [UW-1:0]         head_upd_s;
    logic [UW-1:0]         wr_upd_s;
    logic [ADDR_WIDTH-1:0] wr_pc_s;
    logic                  full_s;
    logic                  empty_s;
    logic                  accept_s;
    logic                  bypass_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  wr_s;

    // Route each resolved branch: write-through, queue, or drop; pick the write source
    always_comb begin
        in_upd_s = {branch_pc_ex, branch_target_ex, branch_taken_ex};
        accept_s = branch_ex && !flush_req && (state_q == ST_RUN);
        pop_s    = (state_q == ST_RUN) && !flush_req && !empty_s && !tbl_wr_stall;
        bypass_s = accept_s && empty_s && !tbl_wr_stall;
        push_s   = accept_s && !bypass_s && (!full_s || pop_s);
        wr_s     = pop_s || bypass_s;
        if (pop_s) begin
            wr_upd_s = head_upd_s;
        end else begin
            wr_upd_s = in_upd_s;
        end
        wr_pc_s = wr_upd_s[UW-1 -: ADDR_WIDTH];
    end

    bp_upd_fifo #(
        .W     (UW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .cpu_clk  (cpu_clk),
        .cpu_rstn (cpu_rstn),
        .clr_i    (flush_req),
        .push_i   (push_s),
        .pop_i    (pop_s),
        .wdata_i  (in_upd_s),
        .rdata_o  (head_upd_s),
        .full_o   (full_s),
        .empty_o  (empty_s)
    );

    // Clear-walk / update FSM with all write-port and status outputs registered
    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            state_q        <= ST_CLEAR;
            idx_q          <= {IDX_W{1'b0}};
            tbl_wen_q      <= 1'b0;
            tbl_clr_q      <= 1'b0;
            tbl_waddr_q    <= {IDX_W{1'b0}};
            tbl_w_pc_q     <= {ADDR_WIDTH{1'b0}};
            tbl_w_target_q <= {ADDR_WIDTH{1'b0}};
            tbl_w_taken_q  <= 1'b0;
            predict_en_q   <= 1'b0;
            clear_busy_q   <= 1'b1;
        end else begin
            tbl_wen_q <= 1'b0;
            tbl_clr_q <= 1'b0;
            if (flush_req) begin
                // Restart the walk; index 0 is written in this same step when not stalled
                state_q      <= ST_CLEAR;
                predict_en_q <= 1'b0;
                clear_busy_q <= 1'b1;
                if (!tbl_wr_stall) begin
                    tbl_wen_q   <= 1'b1;
                    tbl_clr_q   <= 1'b1;
                    tbl_waddr_q <= {IDX_W{1'b0}};
                    idx_q       <= {{(IDX_W-1){1'b0}}, 1'b1};
                end else begin
                    idx_q <= {IDX_W{1'b0}};
                end
            end else begin
                case (state_q)
                    ST_CLEAR: begin
                        predict_en_q <= 1'b0;
                        clear_busy_q <= 1'b1;
                        if (!tbl_wr_stall) begin
                            tbl_wen_q   <= 1'b1;
                            tbl_clr_q   <= 1'b1;
                            tbl_waddr_q <= idx_q;
                            idx_q       <= idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
                            if (idx_q == IDX_LAST) begin
                                state_q <= ST_RUN;
                            end
                        end
                    end
                    ST_RUN: begin
                        predict_en_q <= 1'b1;
                        clear_busy_q <= 1'b0;
                        if (wr_s) begin
                            tbl_wen_q      <= 1'b1;
                            tbl_waddr_q    <= wr_pc_s[IDX_W+1:2];
                            tbl_w_pc_q     <= wr_pc_s;
                            tbl_w_target_q <= wr_upd_s[ADDR_WIDTH:1];
                            tbl_w_taken_q  <= wr_upd_s[0];
                        end
                    end
                    default: begin
                        state_q      <= ST_CLEAR;
                        idx_q        <= {IDX_W{1'b0}};
                        predict_en_q <= 1'b0;
                        clear_busy_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign tbl_wen      = tbl_wen_q;
    assign tbl_clr      = tbl_clr_q;
    assign tbl_waddr    = tbl_waddr_q;
    assign tbl_w_pc     = tbl_w_pc_q;
    assign tbl_w_target = tbl_w_target_q;
    assign tbl_w_taken  = tbl_w_taken_q;
    assign predict_en   = predict_en_q;
    assign clear_busy   = clear_busy_q;

`ifdef BP_UPDATE_STATS_EN
    logic        drop_s;
    logic [15:0] stat_upd_q;
    logic [15:0] stat_drop_q;

    // A branch that is neither written through nor queued is lost (full, CLEAR or flush)
    always_comb begin
        drop_s = branch_ex && !(bypass_s || push_s);
    end

    // Saturating statistics; survive flush, cleared only by reset
    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            stat_upd_q  <= 16'h0000;
            stat_drop_q <= 16'h0000;
        end else begin
            if (wr_s && (stat_upd_q != 16'hFFFF)) begin
                stat_upd_q <= stat_upd_q + 16'h0001;
            end
            if (drop_s && (stat_drop_q != 16'hFFFF)) begin
                stat_drop_q <= stat_drop_q + 16'h0001;
            end
        end
    end

    assign stat_upd_cnt  = stat_upd_q;
    assign stat_drop_cnt = stat_drop_q;
`endif

endmodule

// File: tb/tb_bp_update_ctrl.sv
// Self-checking bench for bp_update_ctrl: queue-based reference model
// compared every cycle, plus hand-computed literal expectations.
module tb_bp_update_ctrl;
    localparam int NENT  = 256;
    localparam int DEPTH = 2;

    logic        clk;
    logic        rstn;
    logic        flush_req;
    logic        branch_ex;
    logic [31:0] branch_pc_ex;
    logic        branch_taken_ex;
    logic [31:0] branch_target_ex;
    logic        tbl_wr_stall;
    logic        tbl_wen;
    logic        tbl_clr;
    logic [7:0]  tbl_waddr;
    logic [31:0] tbl_w_pc;
    logic [31:0] tbl_w_target;
    logic        tbl_w_taken;
    logic        predict_en;
    logic        clear_busy;
`ifdef BP_UPDATE_STATS_EN
    logic [15:0] stat_upd_cnt;
    logic [15:0] stat_drop_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    bp_update_ctrl dut (
        .cpu_clk          (clk),
        .cpu_rstn         (rstn),
        .flush_req        (flush_req),
        .branch_ex        (branch_ex),
        .branch_pc_ex     (branch_pc_ex),
        .branch_taken_ex  (branch_taken_ex),
        .branch_target_ex (branch_target_ex),
        .tbl_wr_stall     (tbl_wr_stall),
        .tbl_wen          (tbl_wen),
        .tbl_clr          (tbl_clr),
        .tbl_waddr        (tbl_waddr),
        .tbl_w_pc         (tbl_w_pc),
        .tbl_w_target     (tbl_w_target),
        .tbl_w_taken      (tbl_w_taken),
        .predict_en       (predict_en),
        .clear_busy       (clear_busy)
`ifdef BP_UPDATE_STATS_EN
        ,
        .stat_upd_cnt     (stat_upd_cnt),
        .stat_drop_cnt    (stat_drop_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        tk;
    } upd_t;

    upd_t        mq[$];
    bit          m_walk  = 1'b1;
    int          m_idx   = 0;
    int          m_upd   = 0;
    int          m_drop  = 0;
    logic        e_wen   = 1'b0;
    logic        e_clr   = 1'b0;
    logic [7:0]  e_addr  = 8'h00;
    logic [31:0] e_pc    = 32'h0;
    logic [31:0] e_tgt   = 32'h0;
    logic        e_tk    = 1'b0;
    logic        e_pred  = 1'b0;
    logic        e_busy  = 1'b1;

    initial begin
        forever begin
            @(posedge clk or negedge rstn);
            if (!rstn) begin
                mq.delete();
                m_walk = 1'b1; m_idx = 0; m_upd = 0; m_drop = 0;
                e_wen = 1'b0; e_clr = 1'b0; e_addr = 8'h00;
                e_pc = 32'h0; e_tgt = 32'h0; e_tk = 1'b0;
                e_pred = 1'b0; e_busy = 1'b1;
            end else begin
                e_wen = 1'b0;
                e_clr = 1'b0;
                if (flush_req) begin
                    mq.delete();
                    m_walk = 1'b1;
                    m_idx  = 0;
                end
                if (m_walk) begin
                    if (branch_ex) m_drop++;
                    e_pred = 1'b0;
                    e_busy = 1'b1;
                    if (!tbl_wr_stall) begin
                        e_wen  = 1'b1;
                        e_clr  = 1'b1;
                        e_addr = m_idx[7:0];
                        m_idx++;
                        if (m_idx == NENT) m_walk = 1'b0;
                    end
                end else begin
                    upd_t u;
                    e_pred = 1'b1;
                    e_busy = 1'b0;
                    if (branch_ex) begin
                        // room exists if the queue is not full or it drains this cycle
                        if (mq.size() < DEPTH || !tbl_wr_stall) begin
                            u.pc = branch_pc_ex; u.tgt = branch_target_ex; u.tk = branch_taken_ex;
                            mq.push_back(u);
                        end else begin
                            m_drop++;
                        end
                    end
                    if (!tbl_wr_stall && mq.size() > 0) begin
                        u      = mq.pop_front();
                        e_wen  = 1'b1;
                        e_addr = (u.pc / 4) % NENT;
                        e_pc   = u.pc;
                        e_tgt  = u.tgt;
                        e_tk   = u.tk;
                        m_upd++;
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        chk("wen", tbl_wen, e_wen);
        chk("predict_en", predict_en, e_pred);
        chk("clear_busy", clear_busy, e_busy);
        if (e_wen) begin
            chk("clr", tbl_clr, e_clr);
            chk("waddr", tbl_waddr, e_addr);
        end
        if (e_wen && !e_clr) begin
            chk("w_pc", tbl_w_pc, e_pc);
            chk("w_target", tbl_w_target, e_tgt);
            chk("w_taken", tbl_w_taken, e_tk);
        end
`ifdef BP_UPDATE_STATS_EN
        chk("stat_upd", stat_upd_cnt, m_upd);
        chk("stat_drop", stat_drop_cnt, m_drop);
`endif
    end

    // ---------------- stimulus ----------------
    task automatic drv(input bit f, input bit b, input logic [31:0] pc,
                       input logic [31:0] tg, input bit tk, input bit st);
        flush_req        = f;
        branch_ex        = b;
        branch_pc_ex     = pc;
        branch_target_ex = tg;
        branch_taken_ex  = tk;
        tbl_wr_stall     = st;
        @(negedge clk);
    endtask

    task automatic idle();
        drv(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        int wcount;
        rstn = 1'b1;
        flush_req = 1'b0; branch_ex = 1'b0; branch_pc_ex = 32'h0;
        branch_target_ex = 32'h0; branch_taken_ex = 1'b0; tbl_wr_stall = 1'b0;
        #1 rstn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_wen", tbl_wen, 1'b0);
        chk("rst_clr", tbl_clr, 1'b0);
        chk("rst_waddr", tbl_waddr, 8'h00);
        chk("rst_pc", tbl_w_pc, 32'h0);
        chk("rst_target", tbl_w_target, 32'h0);
        chk("rst_taken", tbl_w_taken, 1'b0);
        chk("rst_pred", predict_en, 1'b0);
        chk("rst_busy", clear_busy, 1'b1);

        // Full walk after reset release
        rstn = 1'b1;
        wcount = 0;
        for (int k = 1; k <= 257; k++) begin
            @(negedge clk);
            if (k <= 256 && tbl_wen && tbl_clr) wcount++;
            if (k == 1) chk("walk_first_addr", tbl_waddr, 8'h00);
            if (k == 256) begin
                chk("walk_last_addr", tbl_waddr, 8'hFF);
                chk("walk_last_pred", predict_en, 1'b0);
            end
            if (k == 257) begin
                chk("walk_done_pred", predict_en, 1'b1);
                chk("walk_done_wen", tbl_wen, 1'b0);
            end
        end
        chk("walk_count", wcount, 256);

        // Single update, one-cycle latency
        drv(1'b0, 1'b1, 32'h0000_0104, 32'h0000_0200, 1'b1, 1'b0);
        chk("upd_wen", tbl_wen, 1'b1);
        chk("upd_waddr", tbl_waddr, 8'h41);
        chk("upd_target", tbl_w_target, 32'h0000_0200);
        chk("upd_taken", tbl_w_taken, 1'b1);

        // Three branches under a 3-cycle stall: third dropped
        drv(1'b0, 1'b1, 32'h0000_1008, 32'h0000_AAA0, 1'b0, 1'b1);
        drv(1'b0, 1'b1, 32'h0000_2010, 32'h0000_BBB0, 1'b1, 1'b1);
        drv(1'b0, 1'b1, 32'h0000_300C, 32'h0000_CCC0, 1'b1, 1'b1);
        chk("stall_no_wen", tbl_wen, 1'b0);
        idle();
        chk("stall_first_addr", tbl_waddr, 8'h02);
        chk("stall_first_wen", tbl_wen, 1'b1);
        idle();
        chk("stall_second_addr", tbl_waddr, 8'h04);
        idle();
        chk("stall_third_dropped", tbl_wen, 1'b0);
`ifdef BP_UPDATE_STATS_EN
        chk("stat_drop_lit", stat_drop_cnt, 16'd1);
        chk("stat_upd_lit", stat_upd_cnt, 16'd3);
`endif

        // Flush with two queued updates
        drv(1'b0, 1'b1, 32'h0000_0040, 32'h0000_1111, 1'b1, 1'b1);
        drv(1'b0, 1'b1, 32'h0000_0080, 32'h0000_2222, 1'b0, 1'b1);
        drv(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("flush_clr", tbl_clr, 1'b1);
        chk("flush_addr", tbl_waddr, 8'h00);
        chk("flush_pred", predict_en, 1'b0);
        chk("flush_busy", clear_busy, 1'b1);
        for (int k = 0; k < 99; k++) idle();

        // Flush at walk index 100
        drv(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("reflush_addr", tbl_waddr, 8'h00);
        wcount = 1;
        for (int k = 1; k <= 256; k++) begin
            idle();
            if (tbl_wen && tbl_clr) wcount++;
            if (k == 255) chk("reflush_last_addr", tbl_waddr, 8'hFF);
            if (k == 256) chk("reflush_pred", predict_en, 1'b1);
        end
        chk("reflush_count", wcount, 256);

        // Flush coincident with a branch
        drv(1'b1, 1'b1, 32'h0000_0104, 32'h0000_0300, 1'b1, 1'b0);
        chk("flush_branch_clr", tbl_clr, 1'b1);
        for (int k = 0; k < 256; k++) idle();

        // Randomized traffic with a mid-run reset
        for (int i = 0; i < 3000; i++) begin
            if (i == 600) begin
                #2 rstn = 1'b0;
                idle();
                idle();
                #2 rstn = 1'b1;
            end
            drv(($urandom_range(0, 499) == 0), $urandom_range(0, 1),
                $urandom, $urandom, $urandom_range(0, 1), ($urandom_range(0, 3) == 0));
        end
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
